texture_scheduler: RTL

TEXTURE_SCHEDULER -- requirements
Module: texture_scheduler

---
 rtl/texture_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/texture_scheduler.sv
// Playlist-driven texture scheduler for a persistence-of-vision rotor.
// Sequences texture ROM selects per revolution count; texture changes land only on frame_sync.
module texture_scheduler #(
  parameter int unsigned NUM_TEX  = 2,
  parameter int unsigned PL_DEPTH = 8,
  parameter int unsigned REV_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rev_pulse,
  input  logic                frame_sync,
  input  logic                btn_step,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [15:0]         cfg_wdata,
  output logic [3:0]          texture_idx,
  output logic [2:0]          entry_idx,
  output logic [1:0]          state,
  output logic [REV_BITS-1:0] revs_left
);

  localparam int unsigned TEX_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_LOAD   = 2'd1,
    ST_PLAY   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    entry_d;
  logic [REV_BITS-1:0] revs_d;
  logic [TEX_W-1:0]    pend_q;
  logic [TEX_W-1:0]    pend_d;
  logic                advance;
  logic [TEX_W-1:0]    cur_tex;
  logic [CNT_W-1:0]    cur_cnt;

  logic [TEX_W-1:0]    pl_tex [PL_DEPTH];
  logic [CNT_W-1:0]    pl_cnt [PL_DEPTH];
  logic                play_en;
  logic [IDX_W-1:0]    last_entry;
  logic                loop_en;
  logic [TEX_W-1:0]    manual_tex;
  logic [TEX_W-1:0]    manual_inc;

  logic                unused_wdata;
  assign unused_wdata = ^cfg_wdata[15:12];

  assign state = state_q;

  // Out-of-range texture selects fall back to ROM 0 rather than addressing a missing ROM.
  function automatic logic [TEX_W-1:0] map_tex(input logic [TEX_W-1:0] t);
    return (32'(t) < NUM_TEX) ? t : TEX_W'(0);
  endfunction

  assign manual_inc = (32'(manual_tex) + 32'd1 >= NUM_TEX) ? TEX_W'(0) : manual_tex + TEX_W'(1);

  // Configuration registers; a cfg write to the manual register wins over a button step.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PL_DEPTH; i++) begin
        pl_tex[IDX_W'(i)] <= TEX_W'(0);
        pl_cnt[IDX_W'(i)] <= CNT_W'(1);
      end
      play_en    <= 1'b0;
      last_entry <= IDX_W'(0);
      loop_en    <= 1'b0;
      manual_tex <= TEX_W'(0);
    end else begin
      if (cfg_we && !cfg_addr[3] && (32'(cfg_addr[2:0]) < PL_DEPTH)) begin
        pl_tex[cfg_addr[2:0]] <= cfg_wdata[3:0];
        pl_cnt[cfg_addr[2:0]] <= cfg_wdata[11:4];
      end
      if (cfg_we && (cfg_addr == 4'd8)) begin
        play_en    <= cfg_wdata[0];
        last_entry <= cfg_wdata[3:1];
        loop_en    <= cfg_wdata[4];
      end
      if (cfg_we && (cfg_addr == 4'd9)) begin
        manual_tex <= cfg_wdata[3:0];
      end else if (btn_step && (state_q == ST_MANUAL)) begin
        manual_tex <= manual_inc;
      end
    end
  end

  // Next-state and datapath updates; all reads use register values held before this edge.
  always_comb begin
    state_d = state_q;
    entry_d = entry_idx;
    revs_d  = revs_left;
    pend_d  = pend_q;
    advance = 1'b0;
    cur_tex = pl_tex[entry_idx];
    cur_cnt = pl_cnt[entry_idx];

    case (state_q)
      ST_MANUAL: begin
        pend_d = map_tex(manual_tex);
        if (play_en) begin
          state_d = ST_LOAD;
          entry_d = IDX_W'(0);
        end
      end
      ST_LOAD: begin
        pend_d  = map_tex(cur_tex);
        revs_d  = (cur_cnt == CNT_W'(0)) ? REV_BITS'(1) : REV_BITS'(cur_cnt);
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        advance = btn_step || (rev_pulse && (revs_left == REV_BITS'(1)));
        if (rev_pulse && (revs_left != REV_BITS'(0))) begin
          revs_d = revs_left - REV_BITS'(1);
        end
        if (advance) begin
          if (entry_idx < last_entry) begin
            entry_d = entry_idx + IDX_W'(1);
            state_d = ST_LOAD;
          end else if (loop_en) begin
            entry_d = IDX_W'(0);
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (btn_step) begin
          state_d = ST_LOAD;
          entry_d = IDX_W'(0);
        end
      end
      default: begin
        state_d = ST_MANUAL;
      end
    endcase

    // Clearing play_en aborts any playback regardless of what else happens this cycle.
    if ((state_q != ST_MANUAL) && !play_en) begin
      state_d = ST_MANUAL;
      entry_d = IDX_W'(0);
      revs_d  = REV_BITS'(0);
    end
  end

  // FSM and output registers; texture_idx only moves on frame_sync to avoid tearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_MANUAL;
      entry_idx   <= IDX_W'(0);
      revs_left   <= REV_BITS'(0);
      pend_q      <= TEX_W'(0);
      texture_idx <= TEX_W'(0);
    end else begin
      state_q   <= state_d;
      entry_idx <= entry_d;
      revs_left <= revs_d;
      pend_q    <= pend_d;
      if (frame_sync) begin
        texture_idx <= pend_q;
      end
    end
  end

endmodule
